// File: rtl/pwm_audio_modulator.sv
// pwm_audio_modulator: PCM-to-PWM modulator for the audio output path.
// Unsigned PCM samples arrive over a valid/ready handshake and are buffered
// in a small FIFO. One sample is consumed per PWM period of 2^SAMPLE_W ticks,
// where each tick lasts CLK_DIV clk cycles. If the FIFO is empty at a period
// boundary, an underrun is flagged and midscale is played.
//
// Optional build macro: PWM_HOLD_LAST_EN. When it is defined, an underrun
// replays the last loaded duty instead of midscale.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   enable        run the modulator; when low, the modulator idles and
//                 pwm_out stays low
//   sample_data   unsigned PCM sample
//   sample_valid  sample_data is valid
//   sample_ready  FIFO can accept a sample (registered, not full)
//   pwm_out       registered PWM output to the volume/DAC stage
//   period_start  1-cycle pulse when a new period's duty is loaded
//   underrun      1-cycle pulse when a period starts with the FIFO empty
//   underrun_cnt  saturating count of underruns
module pwm_audio_modulator #(
    parameter int unsigned SAMPLE_W   = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                pwm_out,
    output logic                period_start,
    output logic                underrun,
    output logic [15:0]         underrun_cnt
);

    localparam int unsigned PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned UCNT_W = 16;

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [SAMPLE_W-1:0] PWM_LAST  = '1;
    localparam logic [SAMPLE_W-1:0] MIDSCALE  = SAMPLE_W'(1) << (SAMPLE_W - 1);
    localparam logic [CNT_W-1:0]    FIFO_FULL = CNT_W'(FIFO_DEPTH);

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [SAMPLE_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [SAMPLE_W-1:0] duty_q, duty_d;
    logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                sample_ready_q, sample_ready_d;
    logic                pwm_out_q, pwm_out_d;
    logic                period_start_q, period_start_d;
    logic                underrun_q, underrun_d;
    logic [UCNT_W-1:0]   underrun_cnt_q, underrun_cnt_d;

    logic push_c;
    logic pop_c;
    logic empty_c;
    logic tick_c;
    logic boundary_c;

    // Handshake, prescaler tick and period boundary qualifiers
    always_comb begin
        push_c     = sample_valid && sample_ready_q;
        empty_c    = (count_q == '0);
        tick_c     = enable && (pre_cnt_q == PRE_LAST);
        boundary_c = tick_c && (pwm_cnt_q == PWM_LAST);
        // No bypass: a sample written on an empty-FIFO boundary waits a period
        pop_c      = boundary_c && !empty_c;
    end

    // Next-state for counters, duty, FIFO bookkeeping and registered outputs
    always_comb begin
        // Disabled: park counters so the first enabled cycle is a boundary
        pre_cnt_d      = PRE_LAST;
        pwm_cnt_d      = PWM_LAST;
        duty_d         = duty_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        underrun_d     = 1'b0;
        underrun_cnt_d = underrun_cnt_q;
        period_start_d = boundary_c;

        if (enable) begin
            pre_cnt_d = tick_c ? '0 : pre_cnt_q + PRE_W'(1);
            pwm_cnt_d = tick_c ? pwm_cnt_q + SAMPLE_W'(1) : pwm_cnt_q;
        end

        if (boundary_c) begin
            if (!empty_c) begin
                duty_d = mem_q[rd_ptr_q];
            end else begin
`ifdef PWM_HOLD_LAST_EN
                duty_d = duty_q;
`else
                duty_d = MIDSCALE;
`endif
                underrun_d = 1'b1;
                if (underrun_cnt_q != '1) begin
                    underrun_cnt_d = underrun_cnt_q + UCNT_W'(1);
                end
            end
        end

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        sample_ready_d = (count_d != FIFO_FULL);
        // Compare uses the post-update counter and duty
        pwm_out_d      = enable && (pwm_cnt_d < duty_d);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q      <= PRE_LAST;
            pwm_cnt_q      <= PWM_LAST;
            duty_q         <= MIDSCALE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            sample_ready_q <= 1'b0;
            pwm_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_q         <= duty_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            sample_ready_q <= sample_ready_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    // Sample storage; emptied logically by the pointer/count reset
    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            mem_q[wr_ptr_q] <= sample_data;
        end
    end

    assign sample_ready = sample_ready_q;
    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_pwm_audio_modulator.sv
// tb_pwm_audio_modulator: two modulators share the same stimulus. dut0 runs
// with CLK_DIV=1 and dut1 with CLK_DIV=4. A per-cycle behavioural model
// derives every output from the count of enabled cycles since the last
// restart, and directed phases pin key values to hand-computed constants.
module tb_pwm_audio_modulator;

    localparam int P     = 256;
    localparam int MID   = 128;
    localparam int DEPTH = 4;
    localparam int DIV0  = 1;
    localparam int DIV1  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  sample_data;
    logic        sample_valid;
    logic [1:0]  ready_w, pwm_w, ps_w, ur_w;
    logic [15:0] ucnt0, ucnt1;

    int n_chk  = 0;
    int n_fail = 0;

    pwm_audio_modulator #(.SAMPLE_W(8), .CLK_DIV(DIV0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst(rst), .enable(enable),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(ready_w[0]), .pwm_out(pwm_w[0]),
        .period_start(ps_w[0]), .underrun(ur_w[0]), .underrun_cnt(ucnt0)
    );

    pwm_audio_modulator #(.SAMPLE_W(8), .CLK_DIV(DIV1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .enable(enable),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(ready_w[1]), .pwm_out(pwm_w[1]),
        .period_start(ps_w[1]), .underrun(ur_w[1]), .underrun_cnt(ucnt1)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int k_m[2];
    int duty_m[2];
    int ucnt_m[2];
    int sz_m[2];
    int fifo_m[2][DEPTH];
    bit ready_m[2], pwm_m[2], ps_m[2], ur_m[2];
    bit model_ok = 1'b0;

    // k_m counts enabled cycles since the modulator last restarted. A period
    // begins on every multiple of CLK_DIV*256, and the PWM count is k/CLK_DIV.
    task automatic model_step(input int i);
        int d;
        bit wr;
        d = (i == 0) ? DIV0 : DIV1;
        if (rst) begin
            sz_m[i] = 0; ready_m[i] = 0; pwm_m[i] = 0; ps_m[i] = 0;
            ur_m[i] = 0; ucnt_m[i] = 0; duty_m[i] = MID; k_m[i] = 0;
        end else begin
            wr = sample_valid && ready_m[i];
            ps_m[i] = 0;
            ur_m[i] = 0;
            if (enable) begin
                if (k_m[i] % (d * P) == 0) begin
                    ps_m[i] = 1;
                    if (sz_m[i] > 0) begin
                        duty_m[i] = fifo_m[i][0];
                        for (int j = 0; j < DEPTH - 1; j++) fifo_m[i][j] = fifo_m[i][j+1];
                        sz_m[i]--;
                    end else begin
                        ur_m[i] = 1;
                        if (ucnt_m[i] < 65535) ucnt_m[i]++;
`ifndef PWM_HOLD_LAST_EN
                        duty_m[i] = MID;
`endif
                    end
                end
                pwm_m[i] = ((k_m[i] / d) % P) < duty_m[i];
                k_m[i]++;
            end else begin
                pwm_m[i] = 0;
                k_m[i]   = 0;
            end
            if (wr) begin
                fifo_m[i][sz_m[i]] = int'(sample_data);
                sz_m[i]++;
            end
            ready_m[i] = (sz_m[i] != DEPTH);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
        if (rst) model_ok = 1'b1;
    end

    task automatic cmp(input string nm, input int idx, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s d%0d @%0t: got %0d, expected %0d", nm, idx, $time, act, exp);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        cmp(nm, 0, act, exp);
    endtask

    // Per-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                cmp("sample_ready", i, int'(ready_w[i]), int'(ready_m[i]));
                cmp("pwm_out", i, int'(pwm_w[i]), int'(pwm_m[i]));
                cmp("period_start", i, int'(ps_w[i]), int'(ps_m[i]));
                cmp("underrun", i, int'(ur_w[i]), int'(ur_m[i]));
                cmp("underrun_cnt", i, (i == 0) ? int'(ucnt0) : int'(ucnt1), ucnt_m[i]);
            end
        end
    end

    // High-run length recorder for the directed duty checks
    int runs0[$];
    int runs1[$];
    int run0 = 0;
    int run1 = 0;
    always @(negedge clk) begin
        if (pwm_w[0] === 1'b1) run0++;
        else begin
            if (run0 > 0) runs0.push_back(run0);
            run0 = 0;
        end
        if (pwm_w[1] === 1'b1) run1++;
        else begin
            if (run1 > 0) runs1.push_back(run1);
            run1 = 0;
        end
    end

    function automatic int qget(input int which, input int idx);
        if (which == 0) return (runs0.size() > idx) ? runs0[idx] : -1;
        return (runs1.size() > idx) ? runs1[idx] : -1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_samples(input int n, input int base, input int stride);
        for (int j = 0; j < n; j++) begin
            step();
            sample_valid = 1'b1;
            sample_data  = 8'(base + j * stride);
        end
        step();
        sample_valid = 1'b0;
    endtask

    int hi, lo, up, mode;

    initial begin
        rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = 8'h00;

        // Reset values and sample_ready release timing
        step(); step();
        @(negedge clk);
        chk("ready_in_reset", int'(ready_w[0]), 0);
        chk("pwm_in_reset", int'(pwm_w[0]), 0);
        chk("ucnt_in_reset", int'(ucnt1), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_at_release", int'(ready_w[0]), 0);
        step();
        @(negedge clk);
        chk("ready_after_release", int'(ready_w[0]), 1);

        // No samples: underrun every period at midscale
        do_reset();
        runs0.delete(); runs1.delete();
        enable = 1'b1;
        repeat (700) step();
        enable = 1'b0;
        @(negedge clk);
        chk("idle_ucnt_dut0", int'(ucnt0), 3);
        chk("idle_ucnt_dut1", int'(ucnt1), 1);
        chk("idle_ucnt_model", ucnt_m[0], 3);
        chk("idle_high_run0", qget(0, 0), 128);
        chk("idle_high_run1", qget(0, 1), 128);

        // Two samples, then underrun
        do_reset();
        runs0.delete(); runs1.delete();
        push_samples(2, 8'h40, 8'h80);
        enable = 1'b1;
        repeat (800) step();
        enable = 1'b0;
        step();
        @(negedge clk);
        chk("seq_run_p1", qget(0, 0), 64);
        chk("seq_run_p2", qget(0, 1), 192);
`ifdef PWM_HOLD_LAST_EN
        chk("seq_run_p3", qget(0, 2), 192);
`else
        chk("seq_run_p3", qget(0, 2), 128);
`endif
        chk("seq_run_div4", qget(1, 0), 256);

        // Held valid with six samples into a four-entry FIFO
        do_reset();
        runs0.delete(); runs1.delete();
        for (int j = 0; j < 6; j++) begin
            step();
            sample_valid = 1'b1;
            sample_data  = 8'(8'h11 * (j + 1));
        end
        step();
        sample_valid = 1'b0;
        @(negedge clk);
        chk("full_ready_low", int'(ready_w[0]), 0);
        step();
        enable = 1'b1;
        step();
        @(negedge clk);
        chk("ready_after_pop", int'(ready_w[0]), 1);
        chk("period_start_first", int'(ps_w[1]), 1);
        repeat (600) step();
        enable = 1'b0;
        step();
        chk("fifo_order_0", qget(0, 0), 17);
        chk("fifo_order_1", qget(0, 1), 34);

        // Duty extremes with CLK_DIV=4
        do_reset();
        push_samples(2, 8'h00, 8'hFF);
        step();
        enable = 1'b1;
        hi = 0; lo = 0;
        repeat (1024) begin @(negedge clk); hi += int'(pwm_w[1]); end
        repeat (1024) begin @(negedge clk); lo += int'(!pwm_w[1]); end
        chk("duty00_high_clks", hi, 0);
        chk("dutyFF_low_clks", lo, 4);
        step();
        enable = 1'b0;

        // Reset mid-period with three buffered samples
        do_reset();
        enable = 1'b1;
        step();
        enable = 1'b0;
        @(negedge clk);
        chk("pre_rst_ucnt", int'(ucnt0), 1);
        push_samples(4, 200, -1);
        step();
        enable = 1'b1;
        repeat (100) step();
        @(negedge clk);
        chk("pre_rst_pwm", int'(pwm_w[0]), 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pwm_dut0", int'(pwm_w[0]), 0);
        chk("rst_pwm_dut1", int'(pwm_w[1]), 0);
        chk("rst_ucnt", int'(ucnt0), 0);
        step();
        @(negedge clk);
        chk("rst_ready_after", int'(ready_w[0]), 1);
        chk("rst_fifo_empty_dut0", int'(ur_w[0]), 1);
        chk("rst_fifo_empty_dut1", int'(ur_w[1]), 1);
        step();
        enable = 1'b0;

        // Underrun counter saturation with a preloaded near-full count
        do_reset();
        step();
        force dut0.underrun_cnt_q = 16'hFFFC;
        ucnt_m[0] = 65532;
        step();
        release dut0.underrun_cnt_q;
        enable = 1'b1;
        up = 0;
        repeat (1024) begin @(negedge clk); up += int'(ur_w[0]); end
        chk("sat_ucnt", int'(ucnt0), 16'hFFFF);
        chk("sat_pulses", up, 4);
        step();
        enable = 1'b0;

        // Randomized traffic with enable drops and occasional resets
        do_reset();
        enable = 1'b1;
        mode = 0;
        for (int c = 0; c < 20000; c++) begin
            step();
            if (c % 1000 == 0) mode = int'($urandom_range(0, 2));
            rst = ($urandom_range(0, 4999) == 0);
            if ($urandom_range(0, 399) == 0) enable = ~enable;
            case (mode)
                0:       sample_valid = ($urandom_range(0, 1) == 0);
                1:       sample_valid = ($urandom_range(0, 299) == 0);
                default: sample_valid = 1'b1;
            endcase
            case ($urandom_range(0, 7))
                0:       sample_data = 8'h00;
                1:       sample_data = 8'hFF;
                default: sample_data = 8'($urandom_range(0, 255));
            endcase
        end
        step();
        rst = 1'b0; enable = 1'b0; sample_valid = 1'b0;
        step();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_audio_modulator.md
Name: pwm_audio_modulator

Overview:
- Transmit-side PCM-to-PWM modulator feeding the audio output path.
- Accepts unsigned PCM samples over a valid/ready handshake and buffers them in a small FIFO.
- Emits one PWM period per sample; the 1-bit pwm_out drives the downstream volume/DAC stage's PWM input.
- Supplies underrun and period-boundary status to the sample producer (speech playback engine).

Parameters:
- SAMPLE_W, 8, sample width; PWM period = 2^SAMPLE_W ticks.
- CLK_DIV, 4, clk cycles per PWM tick; must be >= 1.
- FIFO_DEPTH, 4, sample FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  run modulator; low = idle.
- sample_data  in  SAMPLE_W  unsigned PCM sample.
- sample_valid  in  1  sample_data valid.
- sample_ready  out  1  FIFO can accept (not full).
- pwm_out  out  1  PWM output to volume stage.
- period_start  out  1  1-cycle pulse when a new period's duty is loaded.
- underrun  out  1  1-cycle pulse: period started with FIFO empty.
- underrun_cnt  out  16  saturating count of underruns.

Behaviour:
- Reset: sample_ready=0 during rst, 1 on first cycle after; FIFO emptied; pwm_out=0; period_start=0; underrun=0; underrun_cnt=0; duty=2^(SAMPLE_W-1) (midscale); pre_cnt=CLK_DIV-1; pwm_cnt=2^SAMPLE_W-1.
- rst asserted mid-period or mid-transfer: all of the above applies next cycle; buffered samples are discarded.
- Handshake: a write occurs when sample_valid && sample_ready. sample_ready = !full, registered from the FIFO count. Data held without ready is not consumed. Writes are accepted regardless of enable.
- Prescaler: when enable, pre_cnt counts 0..CLK_DIV-1 and wraps; tick = enable && pre_cnt==CLK_DIV-1.
- PWM counter: increments on tick and wraps 2^SAMPLE_W-1 -> 0.
- Boundary = tick && pwm_cnt==2^SAMPLE_W-1. At a boundary:
  - FIFO non-empty: pop head into duty.
  - FIFO empty: duty <= midscale; underrun pulses; underrun_cnt increments, saturating at 0xFFFF.
  - In both cases period_start pulses.
- Output: pwm_out <= enable && (pwm_cnt < duty), registered, using post-update counter and duty values. High time per period = duty*CLK_DIV clk. Duty 0 gives constant low; duty 2^SAMPLE_W-1 gives low for exactly one tick per period.
- Simultaneous write and pop in one cycle: both occur and the count is unchanged. Write into an empty FIFO on a boundary cycle: no bypass; underrun is declared and the sample is used next period.
- enable low: pre_cnt/pwm_cnt held at their reset values, pwm_out=0, duty and FIFO retained. The first enabled cycle is therefore a boundary that loads immediately.
- enable dropped mid-period: the period is abandoned and the next enable restarts at a boundary.
- Latency: sample accepted into an empty FIFO appears on pwm_out at the next boundary + 1 clk.

Optional Feature:
- PWM_HOLD_LAST_EN defined: on underrun, duty keeps the last loaded sample instead of midscale. underrun pulse and counter behave identically.
- Undefined: underrun loads midscale (2^(SAMPLE_W-1)).

Test Plan:
- Reset, CLK_DIV=1, enable=1, no samples -> underrun every 256 clk; pwm_out high exactly 128 consecutive clk per period; underrun_cnt counts 1,2,3...
- Write 0x40, 0xC0, then enable, CLK_DIV=1 -> period 1 high 64 clk, period 2 high 192 clk, period 3 underrun at midscale. With PWM_HOLD_LAST_EN, period 3 is high 192.
- Hold sample_valid with 6 samples, DEPTH=4, enable=0 -> 4 accepted; sample_ready=0 afterwards. On enable, one pop per period and ready re-asserts after the first pop.
- Duty 0x00 and 0xFF, CLK_DIV=4 -> pwm_out constant 0; then low for exactly 4 clk per 1024-clk period.
- Assert rst mid-period with 3 buffered samples -> next cycle pwm_out=0, FIFO empty, underrun_cnt=0, sample_ready=1 a cycle after rst release.
- Force 0x10000 underruns -> underrun_cnt saturates at 0xFFFF; underrun still pulses.
